// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - micro-cycle sequencer with instruction register, zero flag and overrun detect
// Optional single-step support is compiled in when SINGLE_STEP_EN is defined.
module cpu_sequencer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] state,
  input  logic [7:0] bus,
  input  logic       alu_zero,
  input  logic       flags_load,
  input  logic       run,
`ifdef SINGLE_STEP_EN
  input  logic       step_mode,
  input  logic       step_req,
  output logic       step_ack,
`endif
  output logic [3:0] cycle,
  output logic [3:0] opcode,
  output logic       eq_zero,
  output logic       running,
  output logic       halted,
  output logic       seq_err
);

  // Control-decoder state codes shared with the rest of the CPU.
  localparam logic [3:0] STATE_FETCH_INST = 4'd2;
  localparam logic [3:0] STATE_NEXT       = 4'd14;
  localparam logic [3:0] STATE_HALT       = 4'd15;

`ifdef SINGLE_STEP_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED, S_WAIT_STEP} fsm_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} fsm_t;
`endif

  fsm_t       fsm_q;
  logic [3:0] cycle_q;
  logic [3:0] opcode_q;
  logic       eq_zero_q;
  logic       seq_err_q;
`ifdef SINGLE_STEP_EN
  logic       step_ack_q;
  logic       step_hold_q;
`endif

  // Only the opcode nibble of the bus is consumed here.
  logic unused_bus_low;
  assign unused_bus_low = ^bus[3:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm_q     <= S_IDLE;
      cycle_q   <= 4'd0;
      opcode_q  <= 4'd0;
      eq_zero_q <= 1'b0;
      seq_err_q <= 1'b0;
`ifdef SINGLE_STEP_EN
      step_ack_q  <= 1'b0;
      step_hold_q <= 1'b0;
`endif
    end else begin
      if (flags_load) eq_zero_q <= alu_zero;
`ifdef SINGLE_STEP_EN
      step_ack_q <= 1'b0;
      // A held step_req must drop before it can release another instruction.
      if (!step_req) step_hold_q <= 1'b0;
`endif
      case (fsm_q)
        S_IDLE: begin
          cycle_q <= 4'd0;
          if (run) fsm_q <= S_RUN;
        end
        S_RUN: begin
          if (state == STATE_FETCH_INST) opcode_q <= bus[7:4];
          if (state == STATE_HALT) begin
            fsm_q <= S_HALTED;
          end else if (state == STATE_NEXT) begin
            cycle_q <= 4'd0;
`ifdef SINGLE_STEP_EN
            if (step_mode) fsm_q <= S_WAIT_STEP;
`endif
          end else if (cycle_q == 4'd7) begin
            cycle_q   <= 4'd0;
            seq_err_q <= 1'b1;
          end else begin
            cycle_q <= cycle_q + 4'd1;
          end
        end
`ifdef SINGLE_STEP_EN
        S_WAIT_STEP: begin
          cycle_q <= 4'd0;
          if (step_req && !step_hold_q) begin
            fsm_q       <= S_RUN;
            step_ack_q  <= 1'b1;
            step_hold_q <= 1'b1;
          end
        end
`endif
        S_HALTED: ;
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

  assign cycle   = cycle_q;
  assign opcode  = opcode_q;
  assign eq_zero = eq_zero_q;
  assign seq_err = seq_err_q;
  assign running = (fsm_q == S_RUN);
  assign halted  = (fsm_q == S_HALTED);
`ifdef SINGLE_STEP_EN
  assign step_ack = step_ack_q;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench for cpu_sequencer
module tb_cpu_sequencer;

  localparam logic [3:0] C_FETCH_PC   = 4'd1;
  localparam logic [3:0] C_FETCH_INST = 4'd2;
  localparam logic [3:0] C_GEN        = 4'd5;
  localparam logic [3:0] C_NEXT       = 4'd14;
  localparam logic [3:0] C_HALT       = 4'd15;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] state = 4'd0;
  logic [7:0] bus = 8'd0;
  logic       alu_zero = 1'b0;
  logic       flags_load = 1'b0;
  logic       run = 1'b0;
  logic       step_mode = 1'b0;
  logic       step_req = 1'b0;
  logic       step_ack;
  logic [3:0] cycle;
  logic [3:0] opcode;
  logic       eq_zero;
  logic       running;
  logic       halted;
  logic       seq_err;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .state      (state),
    .bus        (bus),
    .alu_zero   (alu_zero),
    .flags_load (flags_load),
    .run        (run),
`ifdef SINGLE_STEP_EN
    .step_mode  (step_mode),
    .step_req   (step_req),
    .step_ack   (step_ack),
`endif
    .cycle      (cycle),
    .opcode     (opcode),
    .eq_zero    (eq_zero),
    .running    (running),
    .halted     (halted),
    .seq_err    (seq_err)
  );

`ifndef SINGLE_STEP_EN
  assign step_ack = 1'b0;
`endif

  typedef struct {
    string      name;
    logic [3:0] cyc;
    logic [3:0] opc;
    logic       ez;
    logic       rn;
    logic       hl;
    logic       er;
    logic       ack;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Inputs are set at a negedge; tick clocks them in and queues the expected outputs.
  task automatic tick(input string nm, input logic [3:0] c, input logic [3:0] o,
                      input logic ez, input logic rn, input logic hl,
                      input logic er, input logic ack);
    exp_t e;
    e.name = nm; e.cyc = c; e.opc = o; e.ez = ez; e.rn = rn; e.hl = hl; e.er = er; e.ack = ack;
    @(posedge clk);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (cycle !== e.cyc || opcode !== e.opc || eq_zero !== e.ez || running !== e.rn ||
          halted !== e.hl || seq_err !== e.er || step_ack !== e.ack) begin
        bad++;
        $display("FAIL %s: got cyc=%0d opc=%h ez=%b run=%b halt=%b err=%b ack=%b want cyc=%0d opc=%h ez=%b run=%b halt=%b err=%b ack=%b",
                 e.name, cycle, opcode, eq_zero, running, halted, seq_err, step_ack,
                 e.cyc, e.opc, e.ez, e.rn, e.hl, e.er, e.ack);
      end
    end
  end

  initial begin
    @(negedge clk);
    // reset wins over flags_load and run
    reset_n = 1'b0; flags_load = 1'b1; alu_zero = 1'b1; run = 1'b1;
    tick("reset_prio", 4'd0, 4'h0, 0, 0, 0, 0, 0);
    reset_n = 1'b1; run = 1'b0;
    tick("flag_load", 4'd0, 4'h0, 1, 0, 0, 0, 0);
    flags_load = 1'b0; alu_zero = 1'b0;
    tick("idle_hold", 4'd0, 4'h0, 1, 0, 0, 0, 0);

    // start and fetch sequence
    run = 1'b1; state = C_FETCH_PC;
    tick("run_start", 4'd0, 4'h0, 1, 1, 0, 0, 0);
    run = 1'b0;
    tick("fetch_pc", 4'd1, 4'h0, 1, 1, 0, 0, 0);
    state = C_FETCH_INST; bus = 8'hE5;
    tick("fetch_inst", 4'd2, 4'hE, 1, 1, 0, 0, 0);
    state = C_GEN; bus = 8'h35;
    tick("opc_hold", 4'd3, 4'hE, 1, 1, 0, 0, 0);
    tick("gen4", 4'd4, 4'hE, 1, 1, 0, 0, 0);
    tick("gen5", 4'd5, 4'hE, 1, 1, 0, 0, 0);
    state = C_NEXT;
    tick("next_c5", 4'd0, 4'hE, 1, 1, 0, 0, 0);
    state = C_FETCH_PC;
    tick("c1", 4'd1, 4'hE, 1, 1, 0, 0, 0);
    state = C_GEN;
    tick("c2", 4'd2, 4'hE, 1, 1, 0, 0, 0);
    state = C_HALT;
    tick("halt_c2", 4'd2, 4'hE, 1, 0, 1, 0, 0);

    // halted ignores run and fetches; flag still loads
    run = 1'b1; state = C_FETCH_INST; bus = 8'h35;
    for (int i = 0; i < 10; i++) begin
      flags_load = (i == 3);
      tick("halt_hold", 4'd2, 4'hE, (i < 3), 0, 1, 0, 0);
    end
    flags_load = 1'b0;
    reset_n = 1'b0;
    tick("halt_reset", 4'd0, 4'h0, 0, 0, 0, 0, 0);

    // overrun past cycle 7
    reset_n = 1'b1; run = 1'b1; state = C_GEN;
    tick("ovr_start", 4'd0, 4'h0, 0, 1, 0, 0, 0);
    run = 1'b0;
    for (int i = 1; i <= 7; i++) tick("ovr_count", 4'(i), 4'h0, 0, 1, 0, 0, 0);
    tick("ovr_wrap", 4'd0, 4'h0, 0, 1, 0, 1, 0);
    tick("ovr_sticky", 4'd1, 4'h0, 0, 1, 0, 1, 0);
    state = C_NEXT;
    tick("ovr_sticky_next", 4'd0, 4'h0, 0, 1, 0, 1, 0);
    reset_n = 1'b0; run = 1'b1;
    tick("ovr_clear", 4'd0, 4'h0, 0, 0, 0, 0, 0);

    // reset mid-instruction leaves nothing behind
    reset_n = 1'b1; run = 1'b1; state = C_GEN;
    tick("mid_start", 4'd0, 4'h0, 0, 1, 0, 0, 0);
    run = 1'b0; state = C_FETCH_INST; bus = 8'hA0;
    tick("mid_fetch", 4'd1, 4'hA, 0, 1, 0, 0, 0);
    reset_n = 1'b0; state = C_GEN;
    tick("mid_reset", 4'd0, 4'h0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    tick("mid_idle", 4'd0, 4'h0, 0, 0, 0, 0, 0);

`ifdef SINGLE_STEP_EN
    step_mode = 1'b1; run = 1'b1; state = C_GEN;
    tick("ss_start", 4'd0, 4'h0, 0, 1, 0, 0, 0);
    run = 1'b0;
    tick("ss_c1", 4'd1, 4'h0, 0, 1, 0, 0, 0);
    state = C_NEXT;
    tick("ss_wait", 4'd0, 4'h0, 0, 0, 0, 0, 0);
    state = C_GEN;
    for (int i = 0; i < 5; i++) tick("ss_wait_hold", 4'd0, 4'h0, 0, 0, 0, 0, 0);
    step_req = 1'b1;
    tick("ss_release", 4'd0, 4'h0, 0, 1, 0, 0, 1);
    tick("ss_exec", 4'd1, 4'h0, 0, 1, 0, 0, 0);
    state = C_NEXT;
    tick("ss_rewait", 4'd0, 4'h0, 0, 0, 0, 0, 0);
    step_req = 1'b0; state = C_GEN;
    tick("ss_rewait_hold", 4'd0, 4'h0, 0, 0, 0, 0, 0);
    step_req = 1'b1;
    tick("ss_release2", 4'd0, 4'h0, 0, 1, 0, 0, 1);
    step_req = 1'b0; step_mode = 1'b0; state = C_NEXT;
    tick("ss_off_next", 4'd0, 4'h0, 0, 1, 0, 0, 0);
`endif

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
